// File: rtl/cache_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_access_ctrl_if
//  Description : Bundle of fetch, load/store, cache and memory-bus signals
//                seen by cache_access_ctrl.
//  Revision    : 1.0
// ============================================================================
interface cache_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;

    logic              c_read_enable;
    logic              c_write_enable;
    logic [ADDR_W-1:0] c_address;
    logic [31:0]       c_data_in;
    logic [31:0]       c_data_out;
    logic              c_hit;
    logic              c_miss;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_valid;

    // Controller side.
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               c_data_out, c_hit, c_miss, m_rdata, m_valid,
        output i_ready, i_rdata, d_ready, d_rdata,
               c_read_enable, c_write_enable, c_address, c_data_in,
               m_req, m_we, m_addr, m_wdata
    );

    // Requesters, cache and memory side.
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
               c_data_out, c_hit, c_miss, m_rdata, m_valid,
        input  i_ready, i_rdata, d_ready, d_rdata,
               c_read_enable, c_write_enable, c_address, c_data_in,
               m_req, m_we, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_access_ctrl
//  Description : Shares a single-port data cache between fetch and load/store,
//                with round-robin arbitration, block refill and write-through.
//  Revision    : 1.0
// ============================================================================
module cache_access_ctrl #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    cache_access_ctrl_if.master  bus
);
    localparam int c_cnt_w = $clog2(BLOCK_WORDS);
    localparam int c_off_w = c_cnt_w + 2;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_lookup = 3'd1;
    localparam logic [2:0] c_check  = 3'd2;
    localparam logic [2:0] c_refill = 3'd3;
    localparam logic [2:0] c_write  = 3'd4;

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic               r_is_data;
    logic               r_rr_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_wr_first;

    logic               w_grant_d;
    logic [ADDR_W-1:0]  w_base;
    logic               w_last_beat;

    // Data wins when it is the only requester or when the pointer favours it.
    assign w_grant_d   = bus.d_req & (~bus.i_req | r_rr_data);
    assign w_base      = {r_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
    assign w_last_beat = (r_cnt == c_cnt_w'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_is_data  <= 1'b0;
            r_rr_data  <= 1'b1;
            r_cnt      <= '0;
            r_wr_first <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.i_req | bus.d_req) begin
                        r_is_data <= w_grant_d;
                        r_addr    <= w_grant_d ? bus.d_addr : bus.i_addr;
                        r_we      <= w_grant_d & bus.d_we;
                        r_wdata   <= bus.d_wdata;
                        if (bus.i_req & bus.d_req) begin
                            r_rr_data <= ~w_grant_d;
                        end
                        r_state <= c_lookup;
                    end
                end
                c_lookup: r_state <= c_check;
                c_check: begin
                    // Anything other than a clean hit is handled as a miss.
                    if (bus.c_hit) begin
                        r_state    <= r_we ? c_write : c_idle;
                        r_wr_first <= r_we;
                    end else begin
                        r_state <= c_refill;
                        r_cnt   <= '0;
                    end
                end
                c_refill: begin
                    if (bus.m_valid) begin
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= c_lookup;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                c_write: begin
                    r_wr_first <= 1'b0;
                    if (bus.m_valid) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    always_comb begin
        bus.i_ready        = 1'b0;
        bus.i_rdata        = '0;
        bus.d_ready        = 1'b0;
        bus.d_rdata        = '0;
        bus.c_read_enable  = 1'b0;
        bus.c_write_enable = 1'b0;
        bus.c_address      = '0;
        bus.c_data_in      = '0;
        bus.m_req          = 1'b0;
        bus.m_we           = 1'b0;
        bus.m_addr         = '0;
        bus.m_wdata        = '0;
        case (r_state)
            c_lookup: begin
                bus.c_read_enable = 1'b1;
                bus.c_address     = r_addr;
            end
            c_check: begin
                if (bus.c_hit && !r_we) begin
                    if (r_is_data) begin
                        bus.d_ready = 1'b1;
                        bus.d_rdata = bus.c_data_out;
                    end else begin
                        bus.i_ready = 1'b1;
                        bus.i_rdata = bus.c_data_out;
                    end
                end
            end
            c_refill: begin
                bus.m_req  = 1'b1;
                bus.m_addr = w_base;
                if (bus.m_valid) begin
                    bus.c_write_enable = 1'b1;
                    bus.c_address      = w_base + ADDR_W'({r_cnt, 2'b00});
                    bus.c_data_in      = bus.m_rdata;
                end
            end
            c_write: begin
                bus.m_req   = 1'b1;
                bus.m_we    = 1'b1;
                bus.m_addr  = r_addr;
                bus.m_wdata = r_wdata;
                if (r_wr_first) begin
                    bus.c_write_enable = 1'b1;
                    bus.c_address      = r_addr;
                    bus.c_data_in      = r_wdata;
                end
                if (bus.m_valid) begin
                    bus.d_ready = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_access_ctrl
//  Description : Randomized bench for cache_access_ctrl with emulated cache,
//                memory and requesters, checked against a transaction model.
//  Revision    : 1.0
// ============================================================================
module tb_cache_access_ctrl;
    localparam int c_mem_words = 2048;

    logic clk = 1'b0;
    logic reset;

    cache_access_ctrl_if #(.ADDR_W(32)) bus ();

    cache_access_ctrl #(.BLOCK_WORDS(8), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference state: memory contents, cache contents and block valid bits.
    logic [31:0] mem   [c_mem_words];
    logic [31:0] cdata [c_mem_words];
    bit          cvalid[c_mem_words/8];

    // Requesters
    bit          ip, dp, dwe;
    logic [31:0] ia, da, dwd;
    int          dscript;

    // Transaction model
    bit          free, rr_d, lk_pend, post_rst, abort, gd;
    int          serv, grant_cyc, ncomp;
    logic [31:0] s_addr, s_wd;
    bit          s_we;

    // Cache / memory emulation
    bit          cresp_pend, drv_cresp, drv_hit, drv_mv, nx_beat, nx_spur;
    logic [31:0] cresp_addr;
    bit          rf_act, wr_act, wr_first, rst_done, first_store;
    int          rf_beats, wr_delay;
    logic [31:0] rf_base;

    // Sampled outputs
    logic        ir, dr, cre, cwe, mreq, mwe;
    logic [31:0] ca, cdi, maddr, mwd, ird, drd;
    bit          exp_cre, exp_cwe, exp_ir, exp_dr, in_rf, in_wr, hit_rsp;

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 23) * 32 + $urandom_range(0, 7) * 4);
    endfunction

    task automatic complete_txn();
        free = 1;
        if (serv == 1) ip = 0; else dp = 0;
        serv = 0;
        ncomp++;
    endtask

    initial begin
        for (int i = 0; i < c_mem_words; i++) begin
            mem[i]   = $urandom;
            cdata[i] = mem[i];
        end
        for (int b = 0; b < c_mem_words/8; b++) cvalid[b] = 0;
        cvalid[32'h100 >> 5] = 1;
        cvalid[32'h40 >> 5]  = 1;

        reset = 1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.c_data_out = 0;
        bus.c_hit = 0; bus.c_miss = 0; bus.m_rdata = 0; bus.m_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("reset_i_ready", bus.i_ready, 0);
        chk_eq("reset_d_ready", bus.d_ready, 0);
        chk_eq("reset_c_read_enable", bus.c_read_enable, 0);
        chk_eq("reset_c_write_enable", bus.c_write_enable, 0);
        chk_eq("reset_m_req", bus.m_req, 0);
        chk_eq("reset_m_addr", bus.m_addr, 0);

        // Both requesters raised together out of reset.
        free = 1; rr_d = 1; serv = 0; ncomp = 0; dscript = 0; first_store = 1;
        ip = 1; ia = 32'h100;
        dp = 1; da = 32'h1234; dwe = 0; dwd = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            reset = 0;
            if (!rst_done && cyc > 150 && rf_act && rf_beats == 3) begin
                reset = 1;
                rst_done = 1;
            end
            drv_cresp = cresp_pend;
            cresp_pend = 0;
            drv_hit = 0;
            bus.c_hit = 0; bus.c_miss = 0; bus.c_data_out = $urandom;
            if (drv_cresp) begin
                if (cvalid[cresp_addr[12:5]]) begin
                    drv_hit = 1;
                    bus.c_hit = 1;
                    bus.c_data_out = cdata[cresp_addr[12:2]];
                end else begin
                    bus.c_miss = ($urandom_range(0, 3) != 0);
                end
            end
            drv_mv = 0;
            bus.m_valid = 0;
            bus.m_rdata = $urandom;
            if (rf_act && nx_beat) begin
                bus.m_valid = 1;
                bus.m_rdata = mem[rf_base[12:2] + rf_beats];
                drv_mv = 1;
            end else if (wr_act && wr_delay == 0) begin
                bus.m_valid = 1;
                drv_mv = 1;
            end else if (nx_spur) begin
                bus.m_valid = 1;
            end
            bus.i_req = ip; bus.i_addr = ia;
            bus.d_req = dp; bus.d_addr = da; bus.d_we = dwe; bus.d_wdata = dwd;

            @(negedge clk);
            ir = bus.i_ready; dr = bus.d_ready; ird = bus.i_rdata; drd = bus.d_rdata;
            cre = bus.c_read_enable; cwe = bus.c_write_enable;
            ca = bus.c_address; cdi = bus.c_data_in;
            mreq = bus.m_req; mwe = bus.m_we; maddr = bus.m_addr; mwd = bus.m_wdata;

            if (reset) begin
                rf_act = 0; wr_act = 0; wr_first = 0; cresp_pend = 0; lk_pend = 0;
                nx_beat = 0; nx_spur = 0; serv = 0; free = 1; rr_d = 1; post_rst = 1;
                continue;
            end
            if (post_rst) begin
                post_rst = 0;
                chk_eq("post_reset_quiet", {26'b0, ir, dr, cre, cwe, mreq, mwe}, 0);
                chk_eq("post_reset_m_addr", maddr, 0);
            end

            exp_cre = lk_pend;
            lk_pend = 0;
            if (free && (ip || dp)) begin
                if (ip && dp) begin
                    gd = rr_d;
                    rr_d = !gd;
                end else begin
                    gd = dp;
                end
                serv = gd ? 2 : 1;
                s_addr = gd ? da : ia;
                s_we = gd ? dwe : 0;
                s_wd = dwd;
                free = 0;
                grant_cyc = cyc;
                lk_pend = 1;
            end

            in_rf = rf_act;
            in_wr = wr_act;
            hit_rsp = drv_cresp && drv_hit;
            exp_cwe = (in_rf && drv_mv) || (in_wr && wr_first);
            exp_ir = hit_rsp && !s_we && serv == 1;
            exp_dr = (hit_rsp && !s_we && serv == 2) || (in_wr && drv_mv);

            chk_eq("c_read_enable", cre, exp_cre);
            chk_eq("c_write_enable", cwe, exp_cwe);
            chk_eq("m_req", mreq, in_rf || in_wr);
            chk_eq("i_ready", ir, exp_ir);
            chk_eq("d_ready", dr, exp_dr);
            if (cre) begin
                chk_eq("lookup_addr", ca, s_addr);
                cresp_pend = 1;
                cresp_addr = ca;
            end
            if (in_rf) begin
                chk_eq("refill_m_we", mwe, 0);
                chk_eq("refill_m_addr", maddr, rf_base);
            end
            if (in_wr) begin
                chk_eq("write_m_we", mwe, 1);
                chk_eq("write_m_addr", maddr, s_addr);
                chk_eq("write_m_wdata", mwd, s_wd);
            end
            if (exp_ir) begin
                chk_eq("fetch_rdata", ird, mem[s_addr[12:2]]);
                chk_eq("fetch_other_rdata", drd, 0);
            end
            if (exp_dr && !s_we) begin
                chk_eq("load_rdata", drd, mem[s_addr[12:2]]);
                chk_eq("load_other_rdata", ird, 0);
            end

            if (drv_cresp) begin
                if (drv_hit && !s_we) begin
                    complete_txn();
                end else if (drv_hit) begin
                    wr_act = 1;
                    wr_first = 1;
                    wr_delay = first_store ? 5 : $urandom_range(0, 5);
                    first_store = 0;
                end else begin
                    rf_act = 1;
                    rf_beats = 0;
                    rf_base = {s_addr[31:5], 5'b0};
                end
            end
            if (in_rf && drv_mv) begin
                chk_eq("refill_c_address", ca, rf_base + 32'(rf_beats * 4));
                chk_eq("refill_c_data_in", cdi, mem[rf_base[12:2] + rf_beats]);
                cdata[ca[12:2]] = cdi;
                rf_beats++;
                if (rf_beats == 8) begin
                    cvalid[rf_base[12:5]] = 1;
                    rf_act = 0;
                    lk_pend = 1;
                end
            end
            if (in_wr) begin
                if (wr_first) begin
                    chk_eq("store_c_address", ca, s_addr);
                    chk_eq("store_c_data_in", cdi, s_wd);
                    cdata[ca[12:2]] = cdi;
                    wr_first = 0;
                end
                if (drv_mv) begin
                    mem[s_addr[12:2]] = s_wd;
                    wr_act = 0;
                    complete_txn();
                end else begin
                    wr_delay--;
                end
            end

            nx_beat = rf_act && ($urandom_range(0, 2) != 0);
            nx_spur = !rf_act && !wr_act && ($urandom_range(0, 3) == 0);

            if (serv != 0 && cyc - grant_cyc > 300) begin
                chk_eq("txn_timeout", 32'(cyc - grant_cyc), 300);
                abort = 1;
            end
            if (abort) break;

            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1;
                ia = rand_addr();
            end
            if (!dp) begin
                if (dscript == 0) begin
                    dp = 1; da = 32'h40; dwe = 1; dwd = 32'hDEADBEEF;
                    dscript = 1;
                end else if ($urandom_range(0, 2) != 0) begin
                    dp = 1; da = rand_addr(); dwe = ($urandom_range(0, 9) < 4); dwd = $urandom;
                end
            end
        end

        chk_eq("enough_completions", 32'(ncomp >= 100), 1);
        chk_eq("reset_exercised", 32'(rst_done), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
